// File: rtl/spart_bus_intf_if.sv
// Processor-side control and shifter handshake signals of the SPART bus interface.
// The 8-bit tristate databus stays a plain inout port on the block itself.
interface spart_bus_intf_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       baud_en;

    modport slave (
        input  iocs, iorw, ioaddr, tx_busy, rx_data, rx_valid,
        output rda, tbr, tx_data, tx_load, baud_en
    );

    modport master (
        output iocs, iorw, ioaddr, tx_busy, rx_data, rx_valid,
        input  rda, tbr, tx_data, tx_load, baud_en
    );
endinterface

// File: rtl/spart_bus_intf.sv
// SPART register block: processor read/write decode, baud divisor and tick generator,
// single-byte RX buffer with overrun flag, and TX hand-off state machine.
module spart_bus_intf #(
    parameter logic [15:0] DEFAULT_DIV = 16'h028B
) (
    input  logic              clk,
    input  logic              rst,
    spart_bus_intf_if.slave   bus,
    inout  wire  [7:0]        databus
);

    typedef enum logic [1:0] {
        TX_EMPTY = 2'b00,
        TX_FULL  = 2'b01,
        TX_LOAD  = 2'b10
    } tx_state_t;

    tx_state_t   tx_state_r;
    logic [15:0] div_r;
    logic [15:0] cnt_r;
    logic [7:0]  rx_buf_r;
    logic [7:0]  tx_buf_r;
    logic        rda_r;
    logic        ovr_r;
    logic        tbr_r;
    logic        tx_load_r;

    logic        rd_en_s;
    logic        wr_en_s;
    logic        drive_en_s;
    logic        ovr_set_s;
    logic [7:0]  rd_data_s;

    assign rd_en_s    = bus.iocs & bus.iorw;
    assign wr_en_s    = bus.iocs & ~bus.iorw;
    assign drive_en_s = rd_en_s & ~rst;
    // A buffer read on the same edge as new data consumes the old byte, so it is not an overrun.
    assign ovr_set_s  = bus.rx_valid & rda_r & ~(rd_en_s & (bus.ioaddr == 2'b00));

    // Read-data mux selected by the register address
    always_comb begin
        rd_data_s = 8'h00;
        case (bus.ioaddr)
            2'b00:   rd_data_s = rx_buf_r;
            2'b01:   rd_data_s = {5'b00000, ovr_r, tbr_r, rda_r};
            2'b10:   rd_data_s = div_r[7:0];
            2'b11:   rd_data_s = div_r[15:8];
            default: rd_data_s = 8'h00;
        endcase
    end

    assign databus = drive_en_s ? rd_data_s : 8'hzz;

    // Divisor register writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= DEFAULT_DIV;
        end else if (wr_en_s && (bus.ioaddr == 2'b10)) begin
            div_r[7:0] <= databus;
        end else if (wr_en_s && (bus.ioaddr == 2'b11)) begin
            div_r[15:8] <= databus;
        end else begin
            div_r <= div_r;
        end
    end

    // Baud down-counter; a DBL write restarts it from the freshly written divisor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= DEFAULT_DIV;
        end else if (wr_en_s && (bus.ioaddr == 2'b10)) begin
            cnt_r <= {div_r[15:8], databus};
        end else if (cnt_r == 16'h0000) begin
            cnt_r <= div_r;
        end else begin
            cnt_r <= cnt_r - 16'h0001;
        end
    end

    // Receive buffer, data-available and overrun flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_buf_r <= 8'h00;
            rda_r    <= 1'b0;
            ovr_r    <= 1'b0;
        end else begin
            if (bus.rx_valid) begin
                rx_buf_r <= bus.rx_data;
                rda_r    <= 1'b1;
            end else if (rd_en_s && (bus.ioaddr == 2'b00)) begin
                rda_r    <= 1'b0;
            end else begin
                rda_r    <= rda_r;
            end
            if (ovr_set_s) begin
                ovr_r <= 1'b1;
            end else if (rd_en_s && (bus.ioaddr == 2'b01)) begin
                ovr_r <= 1'b0;
            end else begin
                ovr_r <= ovr_r;
            end
        end
    end

    // TX hand-off FSM with registered tbr/tx_load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_EMPTY;
            tx_buf_r   <= 8'h00;
            tbr_r      <= 1'b1;
            tx_load_r  <= 1'b0;
        end else begin
            case (tx_state_r)
                TX_EMPTY: begin
                    if (wr_en_s && (bus.ioaddr == 2'b00)) begin
                        tx_buf_r   <= databus;
                        tx_state_r <= TX_FULL;
                        tbr_r      <= 1'b0;
                    end else begin
                        tbr_r      <= 1'b1;
                    end
                    tx_load_r <= 1'b0;
                end
                TX_FULL: begin
                    if (!bus.tx_busy) begin
                        tx_state_r <= TX_LOAD;
                        tx_load_r  <= 1'b1;
                    end else begin
                        tx_load_r  <= 1'b0;
                    end
                    tbr_r <= 1'b0;
                end
                TX_LOAD: begin
                    tx_state_r <= TX_EMPTY;
                    tx_load_r  <= 1'b0;
                    tbr_r      <= 1'b1;
                end
                default: begin
                    tx_state_r <= TX_EMPTY;
                    tx_load_r  <= 1'b0;
                    tbr_r      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rda     = rda_r;
    assign bus.tbr     = tbr_r;
    assign bus.tx_data = tx_buf_r;
    assign bus.tx_load = tx_load_r;
    assign bus.baud_en = (cnt_r == 16'h0000) & ~rst;

endmodule

// File: doc/spart_bus_intf.md
SPART_BUS_INTF -- requirements
Module: spart_bus_intf

Interface
REQ-001 Parameter: DEFAULT_DIV, 16'h028B, baud divisor loaded at reset (9600 baud setting).
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset are listed first.
REQ-003 clk  input  1  system clock; the block has one clock and every flop SHALL use its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 iocs  input  1  chip select from the processor-side driver.
REQ-006 iorw  input  1  1 = read (the block drives databus), 0 = write (the block samples databus).
REQ-007 ioaddr  input  2  register select: 00 = TX/RX buffer, 01 = status, 10 = divisor low (DBL), 11 = divisor high (DBH).
REQ-008 databus  inout  8  shared data bus.
REQ-009 rda  output  1  receive data available.
REQ-010 tbr  output  1  transmit buffer ready (empty).
REQ-011 tx_data  output  8  byte handed to the TX shifter.
REQ-012 tx_load  output  1  one-cycle strobe that loads tx_data into the shifter.
REQ-013 tx_busy  input  1  TX shifter is currently serializing a byte.
REQ-014 rx_data  input  8  byte from the RX shifter.
REQ-015 rx_valid  input  1  one-cycle strobe that rx_data is valid.
REQ-016 baud_en  output  1  one-cycle baud tick for the shifters.

Function
REQ-017 The block SHALL drive databus only while iocs=1 and iorw=1; it SHALL be high-Z at all other times.
- Read data is combinational from ioaddr: 00 -> rx_buf; 01 -> {5'b0, ovr, tbr, rda}; 10 -> div[7:0]; 11 -> div[15:8].
REQ-018 A write SHALL occur on a rising edge where iocs=1 and iorw=0.
- ioaddr 10 captures databus into div[7:0]; ioaddr 11 captures databus into div[15:8]; ioaddr 01 is ignored.
REQ-019 The baud generator SHALL be a 16-bit down-counter.
- When cnt=0: baud_en=1 for that cycle, and cnt reloads div on the next edge.
- Otherwise cnt decrements by 1 per cycle.
- Period = div+1 cycles; div=0 gives baud_en high every cycle.
REQ-020 A write to DBL SHALL force cnt to reload on the same edge from the new divisor value: {div[15:8], databus}.
- The counter then restarts from the new value; a DBH write alone does not reload cnt.
REQ-021 RX path:
- An edge with rx_valid=1 captures rx_data into rx_buf and sets rda=1.
- If rda was already 1 at that edge, ovr SHALL be set to 1 and rx_buf overwritten.
REQ-022 A read at ioaddr 00 (iocs=1, iorw=1) SHALL clear rda on that edge.
- Simultaneous rx_valid=1 on the same edge takes priority: rda stays 1, rx_buf updates, ovr is not set.
REQ-023 A read at ioaddr 01 SHALL clear ovr on that edge, unless a new overrun occurs on the same edge, in which case ovr=1.
REQ-024 TX state machine states: TX_EMPTY (tbr=1), TX_FULL (tbr=0), TX_LOAD (tbr=0, tx_load=1).
REQ-025 TX_EMPTY -> TX_FULL on a write at ioaddr 00; databus is captured into tx_buf on that edge.
REQ-026 In TX_FULL or TX_LOAD, writes at ioaddr 00 SHALL be ignored and tx_buf SHALL stay unchanged.
REQ-027 TX_FULL -> TX_LOAD when tx_busy=0; TX_FULL otherwise.
REQ-028 TX_LOAD SHALL last exactly one cycle with tx_load=1, then go to TX_EMPTY.
REQ-029 tx_data SHALL equal tx_buf at all times.
REQ-030 tbr SHALL fall on the edge after the accepted write.
- tbr rises the cycle after TX_LOAD, so minimum write-to-tbr-high latency is 2 cycles when tx_busy=0.
REQ-031 rda, tbr, tx_load and baud_en SHALL be registered state outputs or decodes of registered state only, with no combinational path from bus inputs.

Reset
REQ-032 While rst=1, regardless of clock, the block SHALL hold:
- div = DEFAULT_DIV, cnt = DEFAULT_DIV;
- rx_buf = 8'h00, tx_buf = 8'h00;
- rda = 0, ovr = 0, tbr = 1, TX state = TX_EMPTY;
- tx_load = 0, baud_en = 0;
- databus = high-Z.
REQ-033 Reset asserted mid-transmit (TX_FULL or TX_LOAD) SHALL abandon the byte; no tx_load pulse is issued after rst falls until a new write.

Verification
REQ-034 Bench scenarios (stimulus -> required response):
- Reset release, idle: baud_en pulses every 652 cycles; tbr=1; rda=0; status read returns 8'h02.
- Write DBH=8'h00 then DBL=8'hA3: baud_en period becomes 164 cycles, starting from the DBL edge; DBH/DBL reads return 8'h00 and 8'hA3.
- rx_valid with rx_data=8'h5A -> rda=1 next cycle; ioaddr-00 read returns 8'h5A; rda=0 after that edge.
- Two rx_valid pulses (8'h11, 8'h22) with no read -> rx_buf=8'h22, status=8'h07; status read clears ovr, and the next status read returns 8'h03.
- Write 8'hC3 with tx_busy=1 for 10 cycles: tbr=0, tx_load=0 throughout; a second write of 8'hFF is ignored.
  - On tx_busy falling: one tx_load pulse with tx_data=8'hC3, then tbr=1.
- rst pulsed while in TX_FULL -> tbr=1, no tx_load pulse; databus high-Z during reset.
